// File: rtl/plugin_arith_seq.sv
// plugin_arith_seq
// Multi-mode arithmetic coprocessor plugin. A command is accepted on start
// while busy is low. ADD_K, SUB, ACC and ACC_CLR complete in one cycle.
// MUL and MULH run an iterative shift-add multiply over WIDTH cycles.
// All outputs are registered.
//
// Ports:
//   clk        core clock, rising-edge active
//   reset_n    asynchronous active-low reset
//   start      command valid, sampled only while busy = 0
//   op         operation select (see OP_* encodings), sampled with start
//   operand_a  first operand, captured on acceptance
//   operand_b  second operand, captured on acceptance
//   flush      cancels an in-flight MUL/MULH; ignored when idle
//   result     registered result, held until the next completion
//   busy       high while a multiply is in flight
//   done       one-cycle completion pulse
//   err        one-cycle pulse with done for an illegal op
module plugin_arith_seq #(
    parameter int WIDTH     = 32,
    parameter int ADD_CONST = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ADD_K_VAL = WIDTH'(ADD_CONST);

    localparam logic [2:0] OP_ADD_K   = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_ACC     = 3'b010;
    localparam logic [2:0] OP_MUL     = 3'b011;
    localparam logic [2:0] OP_MULH    = 3'b100;
    localparam logic [2:0] OP_ACC_CLR = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     acc_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [CW-1:0]        cnt_r;
    logic                 op_hi_r;

    logic [WIDTH-1:0]     single_res_s;
    logic [WIDTH-1:0]     acc_nxt_s;
    logic                 illegal_s;
    logic                 is_mul_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   prod_nxt_s;

    // Decode the command and compute the single-cycle result and next accumulator.
    always_comb begin
        single_res_s = {WIDTH{1'b0}};
        acc_nxt_s    = acc_r;
        illegal_s    = 1'b0;
        is_mul_s     = 1'b0;
        case (op)
            OP_ADD_K:   single_res_s = operand_a + operand_b + ADD_K_VAL;
            OP_SUB:     single_res_s = operand_a - operand_b;
            OP_ACC: begin
                acc_nxt_s    = acc_r + operand_a;
                single_res_s = acc_nxt_s;
            end
            OP_MUL:     is_mul_s = 1'b1;
            OP_MULH:    is_mul_s = 1'b1;
            OP_ACC_CLR: begin
                acc_nxt_s    = {WIDTH{1'b0}};
                single_res_s = {WIDTH{1'b0}};
            end
            default:    illegal_s = 1'b1;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the upper half
    // (keeping its carry), then shift the whole product right by one.
    always_comb begin
        if (mplier_r[0]) begin
            sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
        end
        prod_nxt_s = {sum_s, prod_r[WIDTH-1:1]};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            op_hi_r  <= 1'b0;
            result   <= {WIDTH{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mul_s) begin
                            mcand_r  <= operand_a;
                            mplier_r <= operand_b;
                            prod_r   <= {(2*WIDTH){1'b0}};
                            cnt_r    <= CW'(WIDTH);
                            op_hi_r  <= (op == OP_MULH);
                            busy     <= 1'b1;
                            state_r  <= ST_MUL;
                        end else begin
                            result <= single_res_s;
                            acc_r  <= acc_nxt_s;
                            done   <= 1'b1;
                            err    <= illegal_s;
                        end
                    end
                end
                ST_MUL: begin
                    // flush wins over a completion in the same cycle
                    if (flush) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        prod_r   <= prod_nxt_s;
                        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                        cnt_r    <= cnt_r - CW'(1);
                        if (cnt_r == CW'(1)) begin
                            if (op_hi_r) begin
                                result <= prod_nxt_s[2*WIDTH-1:WIDTH];
                            end else begin
                                result <= prod_nxt_s[WIDTH-1:0];
                            end
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plugin_arith_seq.sv
// Directed testbench for plugin_arith_seq (WIDTH = 32, ADD_CONST = 5).
module tb_plugin_arith_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    plugin_arith_seq #(.WIDTH(32), .ADD_CONST(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present a command for one cycle; returns in cycle 1 of that command
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        step();
        start     = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic single(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic exp_err);
        issue(o, a, b);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_mul(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int bad;
        bad = 0;
        issue(o, a, b);
        for (int i = 1; i <= 32; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            step();
        end
        chk({tag, "_busywin"}, 32'(bad), 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_result"}, result, exp);
        step();
        chk({tag, "_donepulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        reset_n   = 1'b0;
        start     = 1'b0;
        op        = 3'b000;
        operand_a = 32'd0;
        operand_b = 32'd0;
        flush     = 1'b0;
        step();
        step();
        chk("rst_result", result, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset_n = 1'b1;
        step();

        // 1: ADD_K and wrap
        single("addk", 3'b000, 32'd10, 32'd20, 32'd35, 1'b0);
        step();
        chk("addk_donepulse", {31'd0, done}, 32'd0);
        chk("addk_busy_after", {31'd0, busy}, 32'd0);
        chk("addk_hold", result, 32'd35);
        single("addk_wrap", 3'b000, 32'hFFFF_FFFF, 32'd0, 32'd4, 1'b0);

        // 2: SUB, then back-to-back SUB / ADD_K
        single("sub", 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
        start = 1'b1; op = 3'b001; operand_a = 32'd100; operand_b = 32'd1;
        step();
        chk("b2b1_done", {31'd0, done}, 32'd1);
        chk("b2b1_result", result, 32'd99);
        op = 3'b000; operand_a = 32'd1; operand_b = 32'd2;
        step();
        start = 1'b0;
        chk("b2b2_done", {31'd0, done}, 32'd1);
        chk("b2b2_result", result, 32'd8);
        step();
        chk("b2b_end_done", {31'd0, done}, 32'd0);

        // 3: multiplies
        run_mul("mul", 3'b011, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450);
        run_mul("mulh_ff", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mul("mul_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

        // 4: ignored start while busy, then flush
        issue(3'b011, 32'd3, 32'd4);
        for (int i = 0; i < 4; i++) step();
        start = 1'b1; op = 3'b000; operand_a = 32'd1; operand_b = 32'd1;
        step();
        start = 1'b0;
        chk("ign_done", {31'd0, done}, 32'd0);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_result", result, 32'd1);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done !== 1'b0) ndone++;
            step();
        end
        chk("flush_nodone", 32'(ndone), 32'd0);
        flush = 1'b1;
        single("flush_idle", 3'b000, 32'd1, 32'd1, 32'd7, 1'b0);
        flush = 1'b0;

        // 5: accumulator and reset mid-multiply
        single("accclr", 3'b101, 32'd0, 32'd0, 32'd0, 1'b0);
        single("acc7", 3'b010, 32'd7, 32'd0, 32'd7, 1'b0);
        single("acc_wrap", 3'b010, 32'hFFFF_FFFC, 32'd0, 32'd3, 1'b0);
        issue(3'b011, 32'h0001_2345, 32'h0000_0010);
        step();
        step();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_result", result, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        #2;
        reset_n = 1'b1;
        step();
        single("acc_after_rst", 3'b010, 32'd1, 32'd0, 32'd1, 1'b0);

        // 6: illegal op leaves acc unchanged
        single("acc5", 3'b010, 32'd5, 32'd0, 32'd6, 1'b0);
        single("illegal7", 3'b111, 32'd9, 32'd9, 32'd0, 1'b1);
        step();
        chk("illegal_errpulse", {31'd0, err}, 32'd0);
        single("illegal6", 3'b110, 32'd9, 32'd9, 32'd0, 1'b1);
        single("acc_keep", 3'b010, 32'd0, 32'd0, 32'd6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
